// File: rtl/regfile_scoreboard.sv
// Multi-port register file with same-cycle writeback bypass and a per-register
// pending scoreboard; register 0 reads as zero and is never pending.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_BITS  = 4,
  parameter int NUM_REGS   = 16,
  parameter int NUM_READ   = 3,
  parameter int CNT_BITS   = $clog2(NUM_REGS) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*ADDR_BITS-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic                           wr_en,
  input  logic [ADDR_BITS-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           issue_en,
  input  logic [ADDR_BITS-1:0]           issue_addr,
  output logic [CNT_BITS-1:0]            pending_count,
  output logic                           any_pending
);

  localparam int IDX_BITS = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_q;
  logic [NUM_REGS-1:0]   pend_next;
  logic [CNT_BITS-1:0]   count_q;
  logic [CNT_BITS-1:0]   count_next;
  logic                  wr_ok;
  logic                  issue_ok;

  // Register 0 and addresses beyond the implemented file are inert.
  function automatic logic addr_ok(input logic [ADDR_BITS-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  function automatic logic [IDX_BITS-1:0] idx(input logic [ADDR_BITS-1:0] a);
    return IDX_BITS'(a);
  endfunction

  assign wr_ok    = wr_en && addr_ok(wr_addr);
  assign issue_ok = issue_en && addr_ok(issue_addr);

  // Issue is applied after writeback so a same-edge issue leaves the register pending.
  always_comb begin
    pend_next = pend_q;
    if (wr_ok) begin
      pend_next[idx(wr_addr)] = 1'b0;
    end
    if (issue_ok) begin
      pend_next[idx(issue_addr)] = 1'b1;
    end
    count_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_next = count_next + CNT_BITS'(pend_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) begin
        regs_q[idx(wr_addr)] <= wr_data;
      end
      pend_q  <= pend_next;
      count_q <= count_next;
    end
  end

  // Reads are gated by rst_n so a bypassed writeback cannot leak out during reset.
  always_comb begin
    logic [ADDR_BITS-1:0] a;
    a       = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      a = rd_addr[p*ADDR_BITS +: ADDR_BITS];
      if (rst_n && addr_ok(a)) begin
        if (wr_en && (wr_addr == a)) begin
          rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data;
        end else begin
          rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[idx(a)];
          rd_busy[p]                          = pend_q[idx(a)];
        end
      end
    end
  end

  assign pending_count = count_q;
  assign any_pending   = (count_q != '0);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, randomized run against a
// behavioural model, mid-cycle reset, and a second 8-register / 4-port instance.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic [11:0] a_rd_addr;
  logic [71:0] a_rd_data;
  logic [2:0]  a_rd_busy;
  logic        a_wr_en;
  logic [3:0]  a_wr_addr;
  logic [23:0] a_wr_data;
  logic        a_issue_en;
  logic [3:0]  a_issue_addr;
  logic [4:0]  a_count;
  logic        a_any;

  regfile_scoreboard dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .issue_en(a_issue_en), .issue_addr(a_issue_addr),
    .pending_count(a_count), .any_pending(a_any)
  );

  // Instance B: 8 registers, 4 read ports, 32-bit data
  logic [11:0]  b_rd_addr;
  logic [127:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_wr_en;
  logic [2:0]   b_wr_addr;
  logic [31:0]  b_wr_data;
  logic         b_issue_en;
  logic [2:0]   b_issue_addr;
  logic [3:0]   b_count;
  logic         b_any;

  regfile_scoreboard #(
    .DATA_WIDTH(32), .ADDR_BITS(3), .NUM_REGS(8), .NUM_READ(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .issue_en(b_issue_en), .issue_addr(b_issue_addr),
    .pending_count(b_count), .any_pending(b_any)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model of instance A
  logic [23:0] mem_m  [16];
  bit          pend_m [16];

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;
    logic        issue_en;
    logic [3:0]  issue_addr;
    logic [11:0] rd;
    logic [71:0] exp_data;
    logic [2:0]  exp_busy;
    logic [4:0]  exp_count;
  } vec_t;

  vec_t vecs [15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [23:0] wd,
                               input logic ie, input logic [3:0] ia, input logic [11:0] ra);
    a_wr_en      = we;
    a_wr_addr    = wa;
    a_wr_data    = wd;
    a_issue_en   = ie;
    a_issue_addr = ia;
    a_rd_addr    = ra;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      mem_m[i]  = '0;
      pend_m[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    if (a_wr_en && a_wr_addr != 0) begin
      mem_m[a_wr_addr]  = a_wr_data;
      pend_m[a_wr_addr] = 0;
    end
    if (a_issue_en && a_issue_addr != 0) pend_m[a_issue_addr] = 1;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 16; i++) c += pend_m[i];
    return c;
  endfunction

  function automatic logic [23:0] model_data(input logic [3:0] a);
    if (a == 0) return '0;
    if (a_wr_en && a_wr_addr == a) return a_wr_data;
    return mem_m[a];
  endfunction

  function automatic logic model_busy(input logic [3:0] a);
    if (a == 0) return 1'b0;
    if (a_wr_en && a_wr_addr == a) return 1'b0;
    return pend_m[a];
  endfunction

  initial begin
    logic [3:0] ra [3];
    int         cnt;

    vecs[0]  = '{1'b1, 4'd5,  24'hABCDEF, 1'b0, 4'd0,  {4'd5, 4'd5, 4'd5},
                 {24'hABCDEF, 24'hABCDEF, 24'hABCDEF}, 3'b000, 5'd0};
    vecs[1]  = '{1'b0, 4'd0,  24'h0,      1'b0, 4'd0,  {4'd0, 4'd5, 4'd5},
                 {24'h0, 24'hABCDEF, 24'hABCDEF}, 3'b000, 5'd0};
    vecs[2]  = '{1'b1, 4'd0,  24'h123456, 1'b1, 4'd0,  {4'd0, 4'd0, 4'd0},
                 {24'h0, 24'h0, 24'h0}, 3'b000, 5'd0};
    vecs[3]  = '{1'b0, 4'd0,  24'h0,      1'b1, 4'd3,  {4'd5, 4'd7, 4'd3},
                 {24'hABCDEF, 24'h0, 24'h0}, 3'b000, 5'd1};
    vecs[4]  = '{1'b0, 4'd0,  24'h0,      1'b1, 4'd7,  {4'd5, 4'd7, 4'd3},
                 {24'hABCDEF, 24'h0, 24'h0}, 3'b001, 5'd2};
    vecs[5]  = '{1'b1, 4'd3,  24'h000011, 1'b0, 4'd0,  {4'd0, 4'd7, 4'd3},
                 {24'h0, 24'h0, 24'h000011}, 3'b010, 5'd1};
    vecs[6]  = '{1'b0, 4'd0,  24'h0,      1'b1, 4'd9,  {4'd7, 4'd9, 4'd3},
                 {24'h0, 24'h0, 24'h000011}, 3'b100, 5'd2};
    vecs[7]  = '{1'b1, 4'd9,  24'h5A5A5A, 1'b1, 4'd9,  {4'd3, 4'd9, 4'd9},
                 {24'h000011, 24'h5A5A5A, 24'h5A5A5A}, 3'b000, 5'd2};
    vecs[8]  = '{1'b0, 4'd0,  24'h0,      1'b0, 4'd0,  {4'd3, 4'd7, 4'd9},
                 {24'h000011, 24'h0, 24'h5A5A5A}, 3'b011, 5'd2};
    vecs[9]  = '{1'b1, 4'd12, 24'h777777, 1'b1, 4'd12, {4'd0, 4'd0, 4'd12},
                 {24'h0, 24'h0, 24'h777777}, 3'b000, 5'd3};
    vecs[10] = '{1'b1, 4'd12, 24'h000001, 1'b0, 4'd0,  {4'd9, 4'd12, 4'd12},
                 {24'h5A5A5A, 24'h000001, 24'h000001}, 3'b100, 5'd2};
    vecs[11] = '{1'b1, 4'd4,  24'hFFFFFF, 1'b0, 4'd0,  {4'd7, 4'd9, 4'd4},
                 {24'h0, 24'h5A5A5A, 24'hFFFFFF}, 3'b110, 5'd2};
    vecs[12] = '{1'b0, 4'd0,  24'h0,      1'b1, 4'd1,  {4'd1, 4'd1, 4'd1},
                 {24'h0, 24'h0, 24'h0}, 3'b000, 5'd3};
    vecs[13] = '{1'b1, 4'd1,  24'h222222, 1'b0, 4'd0,  {4'd1, 4'd1, 4'd1},
                 {24'h222222, 24'h222222, 24'h222222}, 3'b000, 5'd2};
    vecs[14] = '{1'b0, 4'd0,  24'h0,      1'b0, 4'd0,  {4'd1, 4'd1, 4'd1},
                 {24'h222222, 24'h222222, 24'h222222}, 3'b000, 5'd2};

    rst_n = 1'b0;
    applyStimulus(1'b0, 4'd0, 24'h0, 1'b0, 4'd0, 12'h0);
    b_rd_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_issue_en = 1'b0; b_issue_addr = '0;
    model_clear();
    #1;
    checkOutput("reset pending_count", 32'(a_count), 32'd0);
    checkOutput("reset any_pending", 32'(a_any), 32'd0);
    checkOutput("reset rd_busy", 32'(a_rd_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].wr_en, vecs[v].wr_addr, vecs[v].wr_data,
                    vecs[v].issue_en, vecs[v].issue_addr, vecs[v].rd);
      #1;
      for (int p = 0; p < 3; p++)
        checkOutput($sformatf("vec%0d rd_data p%0d", v, p),
                    32'(a_rd_data[p*24 +: 24]), 32'(vecs[v].exp_data[p*24 +: 24]));
      checkOutput($sformatf("vec%0d rd_busy", v), 32'(a_rd_busy), 32'(vecs[v].exp_busy));
      @(posedge clk);
      model_edge();
      #1;
      checkOutput($sformatf("vec%0d pending_count", v), 32'(a_count), 32'(vecs[v].exp_count));
      checkOutput($sformatf("vec%0d any_pending", v), 32'(a_any), 32'(vecs[v].exp_count != 0));
      @(negedge clk);
    end

    // Randomized run against the model
    for (int n = 0; n < 300; n++) begin
      a_wr_en      = 1'($urandom_range(0, 1));
      a_wr_addr    = 4'($urandom);
      a_wr_data    = 24'($urandom);
      a_issue_en   = 1'($urandom_range(0, 1));
      a_issue_addr = 4'($urandom);
      for (int p = 0; p < 3; p++)
        ra[p] = ($urandom_range(0, 3) == 0) ? a_wr_addr : 4'($urandom);
      a_rd_addr = {ra[2], ra[1], ra[0]};
      #1;
      for (int p = 0; p < 3; p++) begin
        checkOutput($sformatf("rand%0d rd_data p%0d", n, p),
                    32'(a_rd_data[p*24 +: 24]), 32'(model_data(ra[p])));
        checkOutput($sformatf("rand%0d rd_busy p%0d", n, p),
                    32'(a_rd_busy[p]), 32'(model_busy(ra[p])));
      end
      @(posedge clk);
      model_edge();
      #1;
      cnt = model_count();
      checkOutput($sformatf("rand%0d pending_count", n), 32'(a_count), 32'(cnt));
      checkOutput($sformatf("rand%0d any_pending", n), 32'(a_any), 32'(cnt != 0));
      @(negedge clk);
    end

    // Mid-cycle reset with live state and an active bypass candidate
    applyStimulus(1'b0, 4'd0, 24'h0, 1'b1, 4'd2, 12'h0);
    @(posedge clk);
    model_edge();
    #1;
    checkOutput("pre-reset pending nonzero", 32'(a_any), 32'd1);
    applyStimulus(1'b1, 4'd5, 24'h777777, 1'b0, 4'd0, {4'd5, 4'd2, 4'd5});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset rd_data", 32'(a_rd_data != '0), 32'd0);
    checkOutput("mid reset rd_busy", 32'(a_rd_busy), 32'd0);
    checkOutput("mid reset pending_count", 32'(a_count), 32'd0);
    checkOutput("mid reset any_pending", 32'(a_any), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    applyStimulus(1'b0, 4'd0, 24'h0, 1'b0, 4'd0, {4'd5, 4'd2, 4'd1});
    #1;
    checkOutput("post reset rd_data", 32'(a_rd_data != '0), 32'd0);
    checkOutput("post reset rd_busy", 32'(a_rd_busy), 32'd0);
    @(negedge clk);

    // Instance B: fill r1..r7, then mark all pending
    for (int i = 1; i < 8; i++) begin
      b_wr_en = 1'b1; b_wr_addr = 3'(i); b_wr_data = 32'h1000_0000 + 32'(i) * 32'h111;
      @(posedge clk); #1;
      @(negedge clk);
    end
    b_wr_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      b_issue_en = 1'b1; b_issue_addr = 3'(i);
      @(posedge clk); #1;
      checkOutput($sformatf("B pending_count after issue r%0d", i), 32'(b_count), 32'(i));
      @(negedge clk);
    end
    b_issue_addr = 3'd1;
    @(posedge clk); #1;
    checkOutput("B pending_count re-issue", 32'(b_count), 32'd7);
    checkOutput("B any_pending", 32'(b_any), 32'd1);
    @(negedge clk);
    b_issue_en = 1'b0;
    b_rd_addr = {3'd7, 3'd5, 3'd3, 3'd1};
    #1;
    for (int p = 0; p < 4; p++)
      checkOutput($sformatf("B rd_data p%0d", p), b_rd_data[p*32 +: 32],
                  32'h1000_0000 + 32'(2*p+1) * 32'h111);
    checkOutput("B rd_busy all", 32'(b_rd_busy), 32'hF);
    b_wr_en = 1'b1; b_wr_addr = 3'd3; b_wr_data = 32'hDEADBEEF;
    #1;
    checkOutput("B bypass rd_data p1", b_rd_data[32 +: 32], 32'hDEADBEEF);
    checkOutput("B bypass rd_busy", 32'(b_rd_busy), 32'hD);
    @(posedge clk); #1;
    checkOutput("B pending_count after wb", 32'(b_count), 32'd6);
    @(negedge clk);
    b_wr_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
